mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port RAM between the multicycle CPU's memory path (post IorD mux) and a DMA/program-loader port. Memory control is driven combinationally from the granted requester. Read data is registered per port. `cpu_stall` tells the CPU control sequencer to hold its state while it lacks a grant. Requesters may lock the memory for bounded bursts.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_pick.sv | 48 ++++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the CPU/DMA memory arbiter.
// Round-robin contention is enabled by defining MEMARB_RR_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN_CPU = 2'd1,
        ST_OWN_DMA = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int BCNT_W = 8;

    // Ownership state that corresponds to a given port.
    function automatic arb_state_t own_state(input logic port);
        return port ? ST_OWN_DMA : ST_OWN_CPU;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory arbiter.
// MEMARB_RR_EN: contention goes to the port that did not win last.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  arb_state_t state,
    output logic       winner,
    output logic       valid
);

`ifndef MEMARB_RR_EN
    logic unused_last;
    assign unused_last = last;
`endif

    // Owner-only grant while locked, otherwise open arbitration.
    always_comb begin
        winner = PORT_CPU;
        valid  = 1'b0;
        case (state)
            ST_OWN_CPU: begin
                winner = PORT_CPU;
                valid  = req[PORT_CPU];
            end
            ST_OWN_DMA: begin
                winner = PORT_DMA;
                valid  = req[PORT_DMA];
            end
            default: begin
                valid = |req;
                if (req[PORT_CPU] && req[PORT_DMA]) begin
`ifdef MEMARB_RR_EN
                    winner = ~last;
`else
                    winner = PORT_CPU;
`endif
                end else if (req[PORT_DMA]) begin
                    winner = PORT_DMA;
                end else begin
                    winner = PORT_CPU;
                end
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for a single-port RAM with bounded lock bursts.
// MEMARB_RR_EN selects round-robin contention; default is CPU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic          CLK,
    input  logic          Rst,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic          cpu_lock,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,

    input  logic          dma_req,
    input  logic          dma_we,
    input  logic          dma_lock,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_rvalid,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    arb_state_t        arb_view;
    logic [BCNT_W-1:0] burst_cnt;
    logic [BCNT_W-1:0] cnt_nxt;
    logic [BCNT_W:0]   cnt_inc;
    logic              burst_done;
    logic              last;
    logic              last_nxt;
    logic              win;
    logic              win_vld;
    logic              gnt_any;
    logic              sel_we;
    logic              sel_lock;
    logic              own_lock;

    // An owner that neither requests nor locks gives the cycle back to arbitration.
    always_comb begin
        arb_view = state;
        if (state == ST_OWN_CPU && !cpu_lock && !cpu_req) begin
            arb_view = ST_IDLE;
        end
        if (state == ST_OWN_DMA && !dma_lock && !dma_req) begin
            arb_view = ST_IDLE;
        end
    end

    mem_arb_pick u_pick (
        .req    ({dma_req, cpu_req}),
        .last   (last),
        .state  (arb_view),
        .winner (win),
        .valid  (win_vld)
    );

    assign gnt_any  = win_vld & ~Rst;
    assign sel_we   = (win == PORT_DMA) ? dma_we : cpu_we;
    assign sel_lock = (win == PORT_DMA) ? dma_lock : cpu_lock;
    assign own_lock = (state == ST_OWN_DMA) ? dma_lock : cpu_lock;

    assign cnt_inc    = {1'b0, burst_cnt} + (BCNT_W + 1)'(1);
    assign burst_done = (cnt_inc == (BCNT_W + 1)'(MAX_BURST));

    // Grants, stall and RAM port muxing from the current winner.
    always_comb begin
        cpu_gnt   = gnt_any & (win == PORT_CPU);
        dma_gnt   = gnt_any & (win == PORT_DMA);
        cpu_stall = cpu_req & ~cpu_gnt;
        mem_addr  = dma_gnt ? dma_addr : cpu_addr;
        mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
        mem_rd    = gnt_any & ~sel_we;
        mem_wr    = gnt_any & sel_we;
    end

    // Next ownership state, burst count and last winner.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = burst_cnt;
        last_nxt  = last;
        if (arb_view == ST_IDLE) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            if (win_vld) begin
                last_nxt = win;
                if (sel_lock && (MAX_BURST > 1)) begin
                    state_nxt = own_state(win);
                    cnt_nxt   = BCNT_W'(1);
                end
            end
        end else begin
            cnt_nxt = cnt_inc[BCNT_W-1:0];
            if (!own_lock || burst_done) begin
                state_nxt = ST_IDLE;
            end
        end
    end

    // Arbiter state register.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
            last      <= PORT_DMA;
        end else begin
            state     <= state_nxt;
            burst_cnt <= cnt_nxt;
            last      <= last_nxt;
        end
    end

    // Per-port read data capture with a one-cycle valid pulse.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            dma_rvalid <= dma_gnt & ~dma_we;
            if (cpu_gnt && !cpu_we) begin
                cpu_rdata <= mem_rdata;
            end
            if (dma_gnt && !dma_we) begin
                dma_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a
// randomized run against a cycle-level ownership model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 4;
`ifdef MEMARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          CLK;
    logic          Rst;
    logic          cpu_req, cpu_we, cpu_lock;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_stall, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dma_req, dma_we, dma_lock;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt, dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd, mem_wr;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] ram [0:255];

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .CLK(CLK), .Rst(Rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Asynchronous-read RAM model behind the arbiter.
    assign mem_rdata = ram[mem_addr[7:0]];
    always @(posedge CLK) begin
        if (mem_wr === 1'b1) ram[mem_addr[7:0]] = mem_wdata;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_lock = 0;
        cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_lock = 0;
        dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        clear_inputs();
        Rst = 1;
        @(negedge CLK);
        Rst = 0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        Rst = 1;
        cpu_req = 1; cpu_lock = 1; dma_req = 1; dma_we = 1;
        #1;
        checks++;
        if ({cpu_gnt, dma_gnt, mem_rd, mem_wr, cpu_stall} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00001",
                     {cpu_gnt, dma_gnt, mem_rd, mem_wr, cpu_stall});
        end
        @(negedge CLK); #1;
        checks++;
        if ({cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_resp: rv=%b/%b rd=%h/%h want all zero",
                     cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata);
        end
        clear_inputs();
        Rst = 0;
    endtask

    task automatic test_cpu_read();
        apply_reset();
        ram[8'h10] = 32'h1234_5678;
        @(negedge CLK);
        cpu_req = 1; cpu_addr = 32'h10;
        #1;
        checks++;
        if ({cpu_gnt, mem_rd, mem_wr, mem_addr} !== {3'b110, 32'h10}) begin
            errors++;
            $display("FAIL cpu_read_gnt: gnt=%b rd=%b wr=%b addr=%h want 1 1 0 10",
                     cpu_gnt, mem_rd, mem_wr, mem_addr);
        end
        @(negedge CLK);
        cpu_req = 0;
        #1;
        checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'h1234_5678}) begin
            errors++;
            $display("FAIL cpu_read_data: rv=%b rd=%h want 1 12345678",
                     cpu_rvalid, cpu_rdata);
        end
        @(negedge CLK); #1;
        checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b0, 32'h1234_5678}) begin
            errors++;
            $display("FAIL cpu_read_hold: rv=%b rd=%h want 0 12345678",
                     cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_contention();
        logic exp_c;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            cpu_req = 1; cpu_we = 0; cpu_addr = 32'h4;
            dma_req = 1; dma_we = 1; dma_addr = 32'h8;
            #1;
            exp_c = RR ? (i % 2 == 0) : 1'b1;
            checks++;
            if ({cpu_gnt, dma_gnt, mem_rd, mem_wr} !==
                {exp_c, ~exp_c, exp_c, ~exp_c}) begin
                errors++;
                $display("FAIL contention[%0d]: cg=%b dg=%b rd=%b wr=%b want cpu=%b",
                         i, cpu_gnt, dma_gnt, mem_rd, mem_wr, exp_c);
            end
        end
    endtask

    task automatic test_dma_burst();
        logic [2:0] exp;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            dma_req = 1; dma_lock = 1; dma_addr = 32'h80;
            cpu_req = (i > 0); cpu_addr = 32'h14;
            #1;
            exp = (i == 0) ? 3'b010 : (i < 4) ? 3'b011 : 3'b100;
            checks++;
            if ({cpu_gnt, dma_gnt, cpu_stall} !== exp ||
                mem_addr !== ((i < 4) ? 32'h80 : 32'h14)) begin
                errors++;
                $display("FAIL dma_burst[%0d]: cg/dg/st=%b addr=%h want %b",
                         i, {cpu_gnt, dma_gnt, cpu_stall}, mem_addr, exp);
            end
        end
    endtask

    task automatic test_early_unlock();
        logic [2:0] exp;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            dma_req  = (i < 2);
            dma_lock = (i == 0);
            cpu_req  = (i > 0);
            #1;
            exp = (i == 0) ? 3'b010 : (i == 1) ? 3'b011 : 3'b100;
            checks++;
            if ({cpu_gnt, dma_gnt, cpu_stall} !== exp) begin
                errors++;
                $display("FAIL early_unlock[%0d]: got %b want %b",
                         i, {cpu_gnt, dma_gnt, cpu_stall}, exp);
            end
        end
    endtask

    task automatic test_lock_hold();
        logic [2:0] exp;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            dma_req  = (i == 0) || (i >= 5);
            dma_lock = (i < 5);
            cpu_req  = (i >= 1) && (i <= 4);
            cpu_lock = (i >= 5);
            #1;
            exp = (i == 0) ? 3'b010 : (i < 4) ? 3'b001 :
                  (i == 4) ? 3'b100 : 3'b010;
            checks++;
            if ({cpu_gnt, dma_gnt, cpu_stall} !== exp) begin
                errors++;
                $display("FAIL lock_hold[%0d]: got %b want %b",
                         i, {cpu_gnt, dma_gnt, cpu_stall}, exp);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        ram[8'h20] = 32'hA5A5_0001;
        @(negedge CLK);
        dma_req = 1; dma_lock = 1; dma_addr = 32'h20;
        #1;
        checks++;
        if (dma_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rst_burst_start: dma_gnt=%b want 1", dma_gnt);
        end
        @(negedge CLK);
        Rst = 1; cpu_req = 1; cpu_addr = 32'h24;
        #1;
        checks++;
        if ({cpu_gnt, dma_gnt, mem_rd, mem_wr, cpu_stall, dma_rvalid, dma_rdata}
            !== {6'b000011, 32'hA5A5_0001}) begin
            errors++;
            $display("FAIL rst_burst_hold: ctl=%b rv=%b rd=%h want 000011 A5A50001",
                     {cpu_gnt, dma_gnt, mem_rd, mem_wr, cpu_stall}, dma_rvalid, dma_rdata);
        end
        @(negedge CLK);
        Rst = 0;
        #1;
        checks++;
        if ({dma_rvalid, dma_rdata, cpu_rvalid, cpu_gnt, dma_gnt}
            !== {1'b0, 32'h0, 3'b010}) begin
            errors++;
            $display("FAIL rst_burst_after: rv=%b rd=%h crv=%b cg=%b dg=%b want 0 0 0 1 0",
                     dma_rvalid, dma_rdata, cpu_rvalid, cpu_gnt, dma_gnt);
        end
    endtask

    task automatic test_dma_write();
        apply_reset();
        @(negedge CLK);
        dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({mem_wr, mem_rd, dma_gnt, mem_addr, mem_wdata}
            !== {3'b101, 32'h40, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL dma_write: wr=%b rd=%b g=%b a=%h d=%h want 1 0 1 40 DEADBEEF",
                     mem_wr, mem_rd, dma_gnt, mem_addr, mem_wdata);
        end
        @(negedge CLK);
        clear_inputs();
        cpu_req = 1; cpu_addr = 32'h40;
        #1;
        checks++;
        if ({mem_wr, mem_rd, cpu_gnt} !== 3'b011) begin
            errors++;
            $display("FAIL dma_write_once: wr=%b rd=%b cg=%b want 0 1 1",
                     mem_wr, mem_rd, cpu_gnt);
        end
        @(negedge CLK);
        clear_inputs();
        #1;
        checks++;
        if ({cpu_rvalid, cpu_rdata, dma_rvalid} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            errors++;
            $display("FAIL dma_write_readback: rv=%b rd=%h drv=%b want 1 DEADBEEF 0",
                     cpu_rvalid, cpu_rdata, dma_rvalid);
        end
    endtask

    task automatic test_random(input int n);
        logic [DW-1:0] mram [0:255];
        logic [DW-1:0] e_rd [2];
        bit            e_rv [2];
        bit            pend [2];
        bit            rq [2];
        bit            lk [2];
        bit            we [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] wd [2];
        logic [AW-1:0] exp_a;
        logic [DW-1:0] exp_w;
        logic [4:0]    exp_c;
        int            owner, held, g;
        bit            lastw, free, rst_now, gwe;

        apply_reset();
        for (int i = 0; i < 256; i++) begin
            mram[i] = $urandom;
            ram[i]  = mram[i];
        end
        owner = -1; held = 0; lastw = 1;
        for (int p = 0; p < 2; p++) begin
            e_rd[p] = '0; e_rv[p] = 0; pend[p] = 0;
            rq[p] = 0; lk[p] = 0; we[p] = 0; ad[p] = '0; wd[p] = '0;
        end

        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            rst_now = ($urandom_range(63) == 0);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    rq[p] = ($urandom_range(3) != 0);
                    we[p] = ($urandom_range(2) == 0);
                    lk[p] = ($urandom_range(1) == 0);
                    ad[p] = $urandom;
                    wd[p] = $urandom;
                end
            end
            Rst = rst_now;
            cpu_req = rq[0]; cpu_we = we[0]; cpu_lock = lk[0];
            cpu_addr = ad[0]; cpu_wdata = wd[0];
            dma_req = rq[1]; dma_we = we[1]; dma_lock = lk[1];
            dma_addr = ad[1]; dma_wdata = wd[1];
            #1;

            g = -1;
            free = 1;
            if (!rst_now) begin
                free = (owner < 0) || (!lk[owner] && !rq[owner]);
                if (!free) g = rq[owner] ? owner : -1;
                else if (rq[0] && rq[1]) g = RR ? (lastw ? 0 : 1) : 0;
                else if (rq[0]) g = 0;
                else if (rq[1]) g = 1;
            end
            gwe   = (g >= 0) ? we[g] : 1'b0;
            exp_c = {g == 0, g == 1, rq[0] && g != 0, g >= 0 && !gwe, g >= 0 && gwe};
            exp_a = (g == 1) ? ad[1] : ad[0];
            exp_w = (g == 1) ? wd[1] : wd[0];

            checks++;
            if ({cpu_gnt, dma_gnt, cpu_stall, mem_rd, mem_wr} !== exp_c) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: cg/dg/st/rd/wr=%b want %b",
                         c, {cpu_gnt, dma_gnt, cpu_stall, mem_rd, mem_wr}, exp_c);
            end
            checks++;
            if ({mem_addr, mem_wdata} !== {exp_a, exp_w}) begin
                errors++;
                $display("FAIL rand_mux[%0d]: addr=%h wdata=%h want %h %h",
                         c, mem_addr, mem_wdata, exp_a, exp_w);
            end
            checks++;
            if ({cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata}
                !== {e_rv[0], e_rd[0], e_rv[1], e_rd[1]}) begin
                errors++;
                $display("FAIL rand_resp[%0d]: cpu %b/%h dma %b/%h want %b/%h %b/%h",
                         c, cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata,
                         e_rv[0], e_rd[0], e_rv[1], e_rd[1]);
            end

            if (rst_now) begin
                owner = -1; held = 0; lastw = 1;
                for (int p = 0; p < 2; p++) begin
                    e_rv[p] = 0; e_rd[p] = '0;
                end
            end else begin
                e_rv[0] = 0; e_rv[1] = 0;
                if (g >= 0) begin
                    if (we[g]) mram[ad[g][7:0]] = wd[g];
                    else begin
                        e_rd[g] = mram[ad[g][7:0]];
                        e_rv[g] = 1;
                    end
                end
                if (!free) begin
                    held++;
                    if (!lk[owner] || held == MB) owner = -1;
                end else if (g >= 0) begin
                    lastw = (g == 1);
                    if (lk[g] && MB > 1) begin
                        owner = g; held = 1;
                    end else begin
                        owner = -1;
                    end
                end else begin
                    owner = -1;
                end
            end
            for (int p = 0; p < 2; p++) pend[p] = rq[p] && (g != p);
        end
        @(negedge CLK);
        clear_inputs();
        Rst = 0;
    endtask

    initial begin
        Rst = 1;
        clear_inputs();
        for (int i = 0; i < 256; i++) ram[i] = '0;
        test_reset();
        test_cpu_read();
        test_contention();
        test_dma_burst();
        test_early_unlock();
        test_lock_hold();
        test_reset_mid_burst();
        test_dma_write();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
